// File: rtl/prog_counter.sv
// Program counter with IDLE/RUN/HALTED sequencing, jumps, relative branches and fetch counting.
// Latency: one cycle from inputs to prog_ctr/running/done/fetch_cnt; all outputs come straight from registers.
// Backpressure: stall holds the PC and fetch_cnt for the cycle; halt_req parks the block until the next start.
// Optional feature macro: PROG_COUNTER_LINK_REG_EN adds call/ret ports and a single-entry link register.
module prog_counter #(
    parameter int D = 9
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         start,
    input  logic         stall,
    input  logic         abs_jump,
    input  logic         rel_branch,
    input  logic         taken,
    input  logic [D-1:0] target,
    input  logic [7:0]   offset,
    input  logic         halt_req,
`ifdef PROG_COUNTER_LINK_REG_EN
    input  logic         call,
    input  logic         ret,
`endif
    output logic [D-1:0] prog_ctr,
    output logic         running,
    output logic         done,
    output logic [15:0]  fetch_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [D-1:0] pc_q, pc_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         running_q, done_q;

    // Sign-extended displacement and the two candidate sequential addresses.
    logic [D-1:0] pc_inc;
    logic [D-1:0] pc_rel;

    assign pc_inc = pc_q + D'(1);
    assign pc_rel = pc_q + D'($signed(offset));

`ifdef PROG_COUNTER_LINK_REG_EN
    logic [D-1:0] link_q, link_d;
`endif

    // Next-state decode: one PC action per RUN cycle, highest priority first.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
`ifdef PROG_COUNTER_LINK_REG_EN
        link_d  = link_q;
`endif
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                // Every other control input is ignored while parked.
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (stall) begin
                    pc_d = pc_q;
                end else begin
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
`ifdef PROG_COUNTER_LINK_REG_EN
                    if (ret) begin
                        pc_d = link_q;
                    end else if (call) begin
                        link_d = pc_inc;
                        pc_d   = target;
                    end else
`endif
                    if (abs_jump) begin
                        pc_d = target;
                    end else if (rel_branch && taken) begin
                        pc_d = pc_rel;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, PC and counter registers; status flags are decoded from the next state so they are registered.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_HALTED);
        end
    end

`ifdef PROG_COUNTER_LINK_REG_EN
    // Single-entry return address captured on call.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            link_q <= '0;
        end else begin
            link_q <= link_d;
        end
    end
`endif

    assign prog_ctr  = pc_q;
    assign running   = running_q;
    assign done      = done_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: sequencing, branching, stall/halt, async reset and optional link register.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
// All expected values are hand-computed constants for D = 9.
module tb_prog_counter;

    localparam int D = 9;

    logic         Clk;
    logic         Reset_n;
    logic         start;
    logic         stall;
    logic         abs_jump;
    logic         rel_branch;
    logic         taken;
    logic [D-1:0] target;
    logic [7:0]   offset;
    logic         halt_req;
`ifdef PROG_COUNTER_LINK_REG_EN
    logic         call;
    logic         ret;
`endif
    logic [D-1:0] prog_ctr;
    logic         running;
    logic         done;
    logic [15:0]  fetch_cnt;

    int n_total;
    int n_pass;

    prog_counter #(.D(D)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .start      (start),
        .stall      (stall),
        .abs_jump   (abs_jump),
        .rel_branch (rel_branch),
        .taken      (taken),
        .target     (target),
        .offset     (offset),
        .halt_req   (halt_req),
`ifdef PROG_COUNTER_LINK_REG_EN
        .call       (call),
        .ret        (ret),
`endif
        .prog_ctr   (prog_ctr),
        .running    (running),
        .done       (done),
        .fetch_cnt  (fetch_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        start      = 1'b0;
        stall      = 1'b0;
        abs_jump   = 1'b0;
        rel_branch = 1'b0;
        taken      = 1'b0;
        target     = '0;
        offset     = '0;
        halt_req   = 1'b0;
`ifdef PROG_COUNTER_LINK_REG_EN
        call       = 1'b0;
        ret        = 1'b0;
`endif
    endtask

    task automatic jump_to(input logic [D-1:0] a);
        clr();
        abs_jump = 1'b1;
        target   = a;
        tick();
        clr();
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        clr();
        Reset_n = 1'b0;
        #12;
        chk("rst_pc",      32'(prog_ctr),  0);
        chk("rst_cnt",     32'(fetch_cnt), 0);
        chk("rst_running", 32'(running),   0);
        chk("rst_done",    32'(done),      0);
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
        chk("idle_running", 32'(running), 0);

        // Controls other than start are ignored in IDLE.
        abs_jump = 1'b1; target = 9'd55; halt_req = 1'b1;
        tick();
        clr();
        chk("idle_ignore_pc",  32'(prog_ctr), 0);
        chk("idle_ignore_run", 32'(running),  0);

        // Start then five plain increments.
        start = 1'b1;
        tick();
        clr();
        chk("start_pc",      32'(prog_ctr),  0);
        chk("start_cnt",     32'(fetch_cnt), 0);
        chk("start_running", 32'(running),   1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("seq_pc", 32'(prog_ctr), 32'(i));
        end
        chk("seq_cnt", 32'(fetch_cnt), 5);

        // Wrap at the top of the address space.
        jump_to(9'd510);
        chk("wrap_510", 32'(prog_ctr), 510);
        tick();
        chk("wrap_511", 32'(prog_ctr), 511);
        tick();
        chk("wrap_0",   32'(prog_ctr), 0);
        chk("wrap_cnt", 32'(fetch_cnt), 8);

        // Relative branches and priority of absolute jump.
        jump_to(9'd10);
        rel_branch = 1'b1; taken = 1'b1; offset = 8'hFC;
        tick();
        clr();
        chk("rel_neg", 32'(prog_ctr), 6);
        rel_branch = 1'b1; taken = 1'b0; offset = 8'h40;
        tick();
        clr();
        chk("rel_not_taken", 32'(prog_ctr), 7);
        abs_jump = 1'b1; rel_branch = 1'b1; taken = 1'b1; target = 9'd100; offset = 8'h05;
        tick();
        clr();
        chk("abs_over_rel", 32'(prog_ctr), 100);
        jump_to(9'd2);
        rel_branch = 1'b1; taken = 1'b1; offset = 8'hFC;
        tick();
        clr();
        chk("rel_wrap_down", 32'(prog_ctr), 510);
        rel_branch = 1'b1; taken = 1'b1; offset = 8'h7F;
        tick();
        clr();
        chk("rel_wrap_up", 32'(prog_ctr), 125);
        chk("rel_cnt", 32'(fetch_cnt), 15);

        // Stall holds PC and count, even with a jump pending; then halt.
        jump_to(9'd20);
        chk("stall_pre_cnt", 32'(fetch_cnt), 16);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; abs_jump = (i == 1); target = 9'd300;
            tick();
            chk("stall_pc", 32'(prog_ctr), 20);
        end
        chk("stall_cnt", 32'(fetch_cnt), 16);
        clr();
        halt_req = 1'b1; stall = 1'b1;
        tick();
        clr();
        chk("halt_pc",      32'(prog_ctr),  20);
        chk("halt_cnt",     32'(fetch_cnt), 16);
        chk("halt_done",    32'(done),      1);
        chk("halt_running", 32'(running),   0);
        abs_jump = 1'b1; target = 9'd77;
        tick();
        clr();
        chk("halted_hold_pc",  32'(prog_ctr), 20);
        chk("halted_hold_cnt", 32'(fetch_cnt), 16);
        start = 1'b1;
        tick();
        clr();
        chk("restart_pc",      32'(prog_ctr),  0);
        chk("restart_cnt",     32'(fetch_cnt), 0);
        chk("restart_running", 32'(running),   1);
        chk("restart_done",    32'(done),      0);

        // start is ignored while running.
        tick();
        start = 1'b1;
        tick();
        clr();
        chk("start_in_run", 32'(prog_ctr), 2);

        // Asynchronous reset between edges mid-run.
        jump_to(9'd37);
        chk("pre_rst_pc", 32'(prog_ctr), 37);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_pc",      32'(prog_ctr),  0);
        chk("async_cnt",     32'(fetch_cnt), 0);
        chk("async_running", 32'(running),   0);
        chk("async_done",    32'(done),      0);
        #1;
        Reset_n = 1'b1;
        tick();
        tick();
        chk("post_rst_pc",      32'(prog_ctr), 0);
        chk("post_rst_running", 32'(running),  0);
        start = 1'b1;
        tick();
        clr();
        tick();
        chk("post_rst_start_pc", 32'(prog_ctr), 1);
        chk("post_rst_running2", 32'(running),  1);

`ifdef PROG_COUNTER_LINK_REG_EN
        // Call / return through the link register.
        jump_to(9'd50);
        call = 1'b1; abs_jump = 1'b1; target = 9'd200;
        tick();
        clr();
        chk("call_pc",   32'(prog_ctr),    200);
        chk("call_link", 32'(dut.link_q),  51);
        tick();
        tick();
        chk("call_inc", 32'(prog_ctr), 202);
        ret = 1'b1; call = 1'b1; target = 9'd9;
        tick();
        clr();
        chk("ret_pc", 32'(prog_ctr), 51);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
